// File: rtl/gol_sequencer_7x7.sv
// Controller for the 7x7 Game of Life datapath: edge-detected buttons to state code/strobes, RUN pacing, end-of-life detection.
// Latency: an input rise registers at edge 1 and drives the registered outputs from edge 2; all outputs are Moore registers.
// Backpressure: none; presses at cell_idx==49, in CLEAR or in states that do not handle them are dropped.
module gol_sequencer_7x7 #(
  parameter int GEN_PERIOD  = 4,
  parameter int MAX_GEN     = 1000,
  parameter int STOP_CYCLES = 2,
  parameter int GEN_W       = 16
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             btn0_in,
  input  logic             btn1_in,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic [48:0]      grid,
  output logic [1:0]       state,
  output logic             btn0,
  output logic             btn1,
  output logic             stop,
  output logic [5:0]       cell_idx,
  output logic [GEN_W-1:0] gen_count,
  output logic             done,
  output logic [1:0]       halt_cause
);

  // HOLD lasts GEN_PERIOD-1 cycles (count 0..GEN_PERIOD-2); CLEAR lasts STOP_CYCLES cycles.
  localparam int HOLD_W = (GEN_PERIOD > 2) ? $clog2(GEN_PERIOD) : 1;
  localparam int CLR_W  = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GEN_PERIOD - 2);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(STOP_CYCLES - 1);
  localparam logic [GEN_W-1:0]  GEN_LIMIT = GEN_W'(MAX_GEN);
  localparam logic [5:0]        CELLS     = 6'd49;

  typedef enum logic [2:0] {S_IDLE, S_PROG, S_STEP, S_HOLD, S_DONE, S_CLEAR} fsm_t;

  fsm_t              fsm, fsm_nxt;
  logic [3:0]        in_cur, in_prv, rise;
  logic              rise_b0, rise_b1, rise_run, rise_stop;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [CLR_W-1:0]  clr_cnt, clr_nxt;
  logic [48:0]       prev_grid, prev_grid_nxt;
  logic [5:0]        cell_nxt;
  logic [GEN_W-1:0]  gen_nxt;
  logic              done_nxt, btn0_nxt, btn1_nxt;
  logic [1:0]        cause_nxt, hit_cause, state_nxt;
  logic              go_clear, go_run;

  assign rise = in_cur & ~in_prv;
  assign {rise_stop, rise_run, rise_b1, rise_b0} = rise;

  // Register each raw input once and keep one cycle of history for rise detection.
  always_ff @(posedge clka) begin
    if (rst) begin
      in_cur <= '0;
      in_prv <= '0;
    end else begin
      in_cur <= {stop_req, run_req, btn1_in, btn0_in};
      in_prv <= in_cur;
    end
  end

  // FSM state register.
  always_ff @(posedge clka) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_nxt;
  end

  // End-of-life classification of the freshly stepped grid, in priority order.
  always_comb begin
    hit_cause = 2'b00;
    if (grid == '0)                                  hit_cause = 2'b01;
    else if (grid == prev_grid)                      hit_cause = 2'b10;
    else if ((MAX_GEN != 0) && (gen_count == GEN_LIMIT)) hit_cause = 2'b11;
  end

  // Next state and next values of every registered output; stop/run overrides applied last.
  always_comb begin
    fsm_nxt       = fsm;
    hold_nxt      = hold_cnt;
    clr_nxt       = clr_cnt;
    prev_grid_nxt = prev_grid;
    cell_nxt      = cell_idx;
    gen_nxt       = gen_count;
    done_nxt      = done;
    cause_nxt     = halt_cause;
    btn0_nxt      = 1'b0;
    btn1_nxt      = 1'b0;
    go_clear      = 1'b0;
    go_run        = 1'b0;
    state_nxt     = 2'b00;
    case (fsm)
      S_IDLE: begin
        // The press that wakes the block is consumed without a strobe.
        if (rise_b0 || rise_b1) begin
          fsm_nxt  = S_PROG;
          cell_nxt = '0;
        end
      end
      S_PROG: begin
        if (rise_stop)     go_clear = 1'b1;
        else if (rise_run) go_run   = 1'b1;
        else if (cell_idx < CELLS) begin
          if (rise_b1) begin
            btn1_nxt = 1'b1;
            cell_nxt = cell_idx + 6'd1;
          end else if (rise_b0) begin
            btn0_nxt = 1'b1;
            cell_nxt = cell_idx + 6'd1;
          end
        end
      end
      S_STEP: begin
        if (gen_count != '1) gen_nxt = gen_count + GEN_W'(1);
        if (rise_stop) go_clear = 1'b1;
        else begin
          fsm_nxt  = S_HOLD;
          hold_nxt = '0;
        end
      end
      S_HOLD: begin
        if (rise_stop) go_clear = 1'b1;
        else if ((hold_cnt == '0) && (hit_cause != 2'b00)) begin
          fsm_nxt   = S_DONE;
          done_nxt  = 1'b1;
          cause_nxt = hit_cause;
        end else begin
          if (hold_cnt == '0) prev_grid_nxt = grid;
          if (hold_cnt == HOLD_LAST) fsm_nxt = S_STEP;
          else                       hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      S_DONE: begin
        if (rise_stop)     go_clear = 1'b1;
        else if (rise_run) go_run   = 1'b1;
      end
      S_CLEAR: begin
        if (clr_cnt == CLR_LAST) fsm_nxt = S_IDLE;
        else                     clr_nxt = clr_cnt + CLR_W'(1);
      end
      default: fsm_nxt = S_IDLE;
    endcase
    if (go_run) begin
      fsm_nxt       = S_STEP;
      gen_nxt       = '0;
      prev_grid_nxt = grid;
      done_nxt      = 1'b0;
      cause_nxt     = 2'b00;
    end
    if (go_clear) begin
      fsm_nxt   = S_CLEAR;
      clr_nxt   = '0;
      cell_nxt  = '0;
      gen_nxt   = '0;
      done_nxt  = 1'b0;
      cause_nxt = 2'b00;
    end
    case (fsm_nxt)
      S_PROG:  state_nxt = 2'b01;
      S_STEP:  state_nxt = 2'b10;
      S_HOLD:  state_nxt = 2'b11;
      S_DONE:  state_nxt = 2'b11;
      default: state_nxt = 2'b00;
    endcase
  end

  // Output and datapath-tracking registers, all loaded from the next-state decode.
  always_ff @(posedge clka) begin
    if (rst) begin
      state      <= 2'b00;
      btn0       <= 1'b0;
      btn1       <= 1'b0;
      stop       <= 1'b0;
      cell_idx   <= '0;
      gen_count  <= '0;
      done       <= 1'b0;
      halt_cause <= 2'b00;
      prev_grid  <= '0;
      hold_cnt   <= '0;
      clr_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      btn0       <= btn0_nxt;
      btn1       <= btn1_nxt;
      stop       <= (fsm_nxt == S_CLEAR);
      cell_idx   <= cell_nxt;
      gen_count  <= gen_nxt;
      done       <= done_nxt;
      halt_cause <= cause_nxt;
      prev_grid  <= prev_grid_nxt;
      hold_cnt   <= hold_nxt;
      clr_cnt    <= clr_nxt;
    end
  end

endmodule

// File: tb/tb_gol_sequencer_7x7.sv
// Bench for gol_sequencer_7x7: acts as the 7x7 datapath and checks strobes, pacing and halt causes against a Life model.
// Latency: samples 1 time unit after each rising edge; datapath effects land one cycle after the strobe/STEP cycle.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_gol_sequencer_7x7;

  localparam int MAXG = 5;
  localparam logic [48:0] BLINKER = 49'h0000003800000;
  localparam logic [48:0] TROMINO = 49'h0000000830000;

  logic        clka = 1'b0;
  logic        rst, btn0_in, btn1_in, run_req, stop_req;
  logic [48:0] grid;
  logic [1:0]  state;
  logic        btn0, btn1, stop;
  logic [5:0]  cell_idx;
  logic [15:0] gen_count;
  logic        done;
  logic [1:0]  halt_cause;

  int n_assert = 0;
  int n_fail   = 0;

  // datapath emulation state
  logic        p_b0 = 1'b0, p_b1 = 1'b0, p_stop = 1'b0, p_step = 1'b0;
  logic [15:0] p_gen = '0;
  int          dp_cur = 0;
  int          kill_gen = 0;
  int          stop_cnt = 0;
  bit          obs_q[$];
  bit          pv[$];

  always #5 clka = ~clka;

  gol_sequencer_7x7 #(.GEN_PERIOD(4), .MAX_GEN(MAXG), .STOP_CYCLES(2), .GEN_W(16)) dut (
    .clka(clka), .rst(rst), .btn0_in(btn0_in), .btn1_in(btn1_in), .run_req(run_req),
    .stop_req(stop_req), .grid(grid), .state(state), .btn0(btn0), .btn1(btn1), .stop(stop),
    .cell_idx(cell_idx), .gen_count(gen_count), .done(done), .halt_cause(halt_cause)
  );

  // One Life generation on a 7x7 board, cells outside the board are dead.
  function automatic logic [48:0] life(input logic [48:0] g);
    logic [48:0] n;
    n = '0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 7; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 7 && (c + dc) >= 0 && (c + dc) < 7)
              cnt += int'(g[(r + dr) * 7 + (c + dc)]);
        n[r * 7 + c] = (cnt == 3) || (g[r * 7 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Predicted halt cause and generation for a run started from g0.
  task automatic predict(input logic [48:0] g0, input int kill, output logic [1:0] cause, output int gens);
    logic [48:0] p, g;
    p = g0; cause = 2'b00; gens = 0;
    for (int k = 1; k <= MAXG; k++) begin
      if (cause == 2'b00) begin
        g = (k == kill) ? '0 : life(p);
        if (g == '0)       cause = 2'b01;
        else if (g == p)   cause = 2'b10;
        else if (k == MAXG) cause = 2'b11;
        if (cause != 2'b00) gens = k;
        p = g;
      end
    end
  endtask

  function automatic logic [48:0] pack(input bit q[$], input int n);
    logic [48:0] r;
    r = '0;
    for (int i = 0; i < n && i < q.size() && i < 49; i++) r[i] = q[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle: apply last cycle's datapath effects, then capture this cycle's outputs.
  task automatic tick();
    @(posedge clka); #1;
    if (p_stop) grid = '0;
    else if (p_step) grid = ((int'(p_gen) + 1) == kill_gen) ? '0 : life(grid);
    else if (p_b0 || p_b1) begin
      if (dp_cur < 49) grid[dp_cur] = p_b1;
      dp_cur++;
    end
    p_b0 = btn0; p_b1 = btn1; p_stop = stop; p_step = (state == 2'b10); p_gen = gen_count;
    if (btn1) obs_q.push_back(1'b1);
    if (btn0) obs_q.push_back(1'b0);
    if (stop) stop_cnt++;
  endtask

  task automatic press(input bit b0, input bit b1, input int hold, input int gap);
    btn0_in = b0; btn1_in = b1;
    repeat (hold) tick();
    btn0_in = 1'b0; btn1_in = 1'b0;
    repeat (gap) tick();
  endtask

  // IDLE -> PROGRAM with a consumed press, then preload the datapath grid.
  task automatic load(input logic [48:0] g);
    press(1'b1, 1'b0, 1, 2);
    chk("load_prog", 64'(state), 64'(1));
    grid = g;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin tick(); k++; end
    chk(tag, 64'(done), 64'(1));
  endtask

  task automatic clear_to_idle(input string tag);
    stop_req = 1'b1; tick(); tick();
    chk({tag, "_stop1"}, 64'(stop), 64'(1));
    chk({tag, "_state1"}, 64'(state), 64'(0));
    chk({tag, "_cell"}, 64'(cell_idx), 64'(0));
    chk({tag, "_gen"}, 64'(gen_count), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_cause"}, 64'(halt_cause), 64'(0));
    stop_req = 1'b0; tick();
    chk({tag, "_stop2"}, 64'(stop), 64'(1));
    tick();
    chk({tag, "_stop_end"}, 64'(stop), 64'(0));
    chk({tag, "_idle"}, 64'(state), 64'(0));
  endtask

  task automatic run_and_check(input string tag, input logic [48:0] g0, input int kill);
    logic [1:0] ec;
    int eg;
    predict(g0, kill, ec, eg);
    kill_gen = kill;
    run_req = 1'b1; tick(); tick();
    chk({tag, "_step"}, 64'(state), 64'(2));
    chk({tag, "_gen0"}, 64'(gen_count), 64'(0));
    chk({tag, "_done0"}, 64'(done), 64'(0));
    run_req = 1'b0;
    wait_done({tag, "_done"});
    chk({tag, "_cause"}, 64'(halt_cause), 64'(ec));
    chk({tag, "_gens"}, 64'(gen_count), 64'(eg));
    chk({tag, "_state"}, 64'(state), 64'(3));
    kill_gen = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required a finished run");
    $fatal(1);
  end

  initial begin
    bit v;
    logic [1:0] ec;
    int eg;
    logic [63:0] r64;
    rst = 1'b1; btn0_in = 1'b0; btn1_in = 1'b0; run_req = 1'b0; stop_req = 1'b0; grid = '0;

    // reset state
    tick(); tick(); rst = 1'b0; tick();
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_btn0", 64'(btn0), 64'(0));
    chk("rst_btn1", 64'(btn1), 64'(0));
    chk("rst_stop", 64'(stop), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cell", 64'(cell_idx), 64'(0));
    chk("rst_gen", 64'(gen_count), 64'(0));
    chk("rst_cause", 64'(halt_cause), 64'(0));

    // enter PROGRAM; the first press is consumed
    obs_q.delete(); pv.delete(); dp_cur = 0;
    btn0_in = 1'b1; tick();
    chk("enter_wait", 64'(state), 64'(0));
    tick();
    chk("enter_prog", 64'(state), 64'(1));
    chk("enter_nostrobe", 64'(btn0), 64'(0));
    btn0_in = 1'b0; tick(); tick();

    // first program press with exact strobe timing
    btn1_in = 1'b1; pv.push_back(1'b1);
    tick(); chk("b1_early", 64'(btn1), 64'(0));
    tick(); chk("b1_strobe", 64'(btn1), 64'(1)); chk("b1_cell", 64'(cell_idx), 64'(1));
    tick(); chk("b1_single", 64'(btn1), 64'(0));
    btn1_in = 1'b0; tick(); tick();

    // remaining sequence 1,1,0,1
    press(1'b0, 1'b1, 3, 2); pv.push_back(1'b1);
    press(1'b0, 1'b1, 3, 2); pv.push_back(1'b1);
    press(1'b1, 1'b0, 3, 2); pv.push_back(1'b0);
    press(1'b0, 1'b1, 3, 2); pv.push_back(1'b1);
    tick(); tick();
    chk("seq_count", 64'(obs_q.size()), 64'(5));
    chk("seq_bits", 64'(pack(obs_q, 5)), 64'(pack(pv, 5)));
    chk("seq_cell", 64'(cell_idx), 64'(5));

    // simultaneous rises: btn1 only
    press(1'b1, 1'b1, 3, 2); pv.push_back(1'b1);
    tick();
    chk("both_count", 64'(obs_q.size()), 64'(6));
    chk("both_is_b1", 64'(obs_q[obs_q.size() - 1]), 64'(1));
    chk("both_cell", 64'(cell_idx), 64'(6));

    // random presses up to 52 total: saturate at 49
    for (int i = 6; i < 52; i++) begin
      v = 1'($urandom_range(0, 1));
      press(!v, v, $urandom_range(1, 4), $urandom_range(1, 3));
      pv.push_back(v);
    end
    tick(); tick(); tick();
    chk("sat_count", 64'(obs_q.size()), 64'(49));
    chk("sat_bits", 64'(pack(obs_q, 49)), 64'(pack(pv, 49)));
    chk("sat_cell", 64'(cell_idx), 64'(49));
    chk("sat_state", 64'(state), 64'(1));

    // run from the programmed grid
    run_and_check("prog_run", pack(pv, 49), 0);
    clear_to_idle("clr_a");

    // pacing and generation limit with a blinker
    load(BLINKER);
    predict(BLINKER, 0, ec, eg);
    run_req = 1'b1; tick(); tick(); run_req = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("pace_state", 64'(state), 64'((i % 4 == 0) ? 2 : 3));
      chk("pace_gen", 64'(gen_count), 64'((i + 3) / 4));
      chk("pace_done", 64'(done), 64'(0));
      tick();
    end
    chk("limit_done", 64'(done), 64'(1));
    chk("limit_cause", 64'(halt_cause), 64'(ec));
    chk("limit_gen", 64'(gen_count), 64'(eg));
    chk("limit_state", 64'(state), 64'(3));
    clear_to_idle("clr_b");

    // still life, then restart from DONE
    load(TROMINO);
    run_and_check("still", TROMINO, 0);
    repeat (3) tick();
    chk("still_hold_state", 64'(state), 64'(3));
    chk("still_hold_done", 64'(done), 64'(1));
    run_and_check("restart", grid, 0);
    clear_to_idle("clr_c");

    // extinct after generation 3
    load(BLINKER);
    run_and_check("extinct", BLINKER, 3);
    clear_to_idle("clr_d");

    // random grids
    for (int i = 0; i < 3; i++) begin
      r64 = {$urandom(), $urandom()};
      load(r64[48:0]);
      run_and_check("rand_run", r64[48:0], 0);
      clear_to_idle("clr_rand");
    end

    // stop mid RUN_HOLD
    load(BLINKER);
    run_req = 1'b1; tick(); tick(); run_req = 1'b0;
    repeat (5) tick();
    chk("hold_before_stop", 64'(state), 64'(3));
    clear_to_idle("hold_stop");

    // stop in IDLE is ignored
    stop_cnt = 0;
    stop_req = 1'b1; repeat (4) tick(); stop_req = 1'b0; tick();
    chk("idle_stop_pulses", 64'(stop_cnt), 64'(0));
    chk("idle_stop_state", 64'(state), 64'(0));

    // reset with a strobe in flight
    load(BLINKER);
    stop_cnt = 0;
    btn1_in = 1'b1; tick();
    rst = 1'b1; tick();
    chk("rstmid_btn1", 64'(btn1), 64'(0));
    chk("rstmid_state", 64'(state), 64'(0));
    chk("rstmid_cell", 64'(cell_idx), 64'(0));
    chk("rstmid_stop", 64'(stop_cnt), 64'(0));
    rst = 1'b0; btn1_in = 1'b0; tick(); tick();
    chk("rstmid_idle", 64'(state), 64'(0));
    chk("rstmid_nostrobe", 64'(btn1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
